progetto_labdig: RTL and testbench

PROGETTO_LABDIG -- requirements
Module: progetto_labdig

---
 rtl/progetto_labdig_if.sv | 25 ++
 rtl/progetto_labdig.sv | 83 ++++++++
 tb/tb_progetto_labdig.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/progetto_labdig_if.sv
// Register bus used to access the scrub error counters.
// The slave side sees a zero-wait request/response port.
interface reg_bus #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ready;
  logic                    error;

  modport slave (
    input  addr, write, wdata, wstrb, valid,
    output rdata, ready, error
  );

  modport master (
    output addr, write, wdata, wstrb, valid,
    input  rdata, ready, error
  );
endinterface

// File: rtl/progetto_labdig.sv
// Scrub error accumulator: counts bit flips reported on scrub_i, exposes
// total / last-cycle / active-cycle counters on a register bus and raises a
// sticky interrupt once the total reaches CYCLE_LIM.
module progetto_labdig #(
  parameter logic [31:0] CYCLE_LIM     = 32'd100,
  parameter int unsigned IN_DATA_WIDTH = 100
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IN_DATA_WIDTH-1:0] scrub_i,
  reg_bus.slave                    bus_if,
  output logic                     interr_o
);

  localparam int unsigned POP_W = $clog2(IN_DATA_WIDTH + 1);

  logic [POP_W-1:0] pop;
  logic [31:0]      err_cnt;
  logic [31:0]      last_cnt;
  logic [31:0]      act_cnt;
  logic [32:0]      err_sum;
  logic [31:0]      err_next;
  logic [31:0]      act_next;
  logic             clear_req;
  logic             unused_bits;

  // Population count of the flips reported this cycle.
  always_comb begin
    pop = '0;
    for (int i = 0; i < IN_DATA_WIDTH; i++) begin
      pop = pop + POP_W'(scrub_i[i]);
    end
  end

  // Saturating next values; the extra sum bit flags overflow of ERR_CNT.
  always_comb begin
    err_sum  = {1'b0, err_cnt} + 33'(pop);
    err_next = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    act_next = ((pop != '0) && (act_cnt != 32'hFFFF_FFFF)) ? act_cnt + 32'd1 : act_cnt;
  end

  assign clear_req = bus_if.valid && bus_if.write && (bus_if.addr == 2'd3) &&
                     bus_if.wstrb[0] && bus_if.wdata[0];

  // Only bit 0 of the control word is meaningful.
  assign unused_bits = ^{bus_if.wdata[31:1], bus_if.wstrb[3:1]};

  assign bus_if.ready = bus_if.valid;

  // Read mux and error decode; reads show pre-edge register values.
  always_comb begin
    bus_if.rdata = '0;
    bus_if.error = 1'b0;
    if (bus_if.valid) begin
      if (!bus_if.write) begin
        case (bus_if.addr)
          2'd0:    bus_if.rdata = err_cnt;
          2'd1:    bus_if.rdata = last_cnt;
          2'd2:    bus_if.rdata = act_cnt;
          default: bus_if.rdata = {31'd0, interr_o};
        endcase
      end else if (bus_if.addr != 2'd3) begin
        bus_if.error = 1'b1;
      end
    end
  end

  // Counter and interrupt registers; a clear discards this cycle's flips.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_req) begin
      err_cnt  <= '0;
      last_cnt <= '0;
      act_cnt  <= '0;
      interr_o <= 1'b0;
    end else begin
      err_cnt  <= err_next;
      last_cnt <= 32'(pop);
      act_cnt  <= act_next;
      interr_o <= interr_o | (err_next >= CYCLE_LIM);
    end
  end

endmodule

// File: tb/tb_progetto_labdig.sv
// Scoreboard bench for progetto_labdig: the driver queues the expected bus
// response for every transfer, a negedge monitor pops and compares.
module tb_progetto_labdig;

  typedef struct packed {
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
    logic        irq;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [99:0] scrub_i;
  logic        interr_o;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  reg_bus #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) bus ();

  progetto_labdig #(.CYCLE_LIM(32'd100), .IN_DATA_WIDTH(100)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scrub_i  (scrub_i),
    .bus_if   (bus),
    .interr_o (interr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every cycle with valid=1 consumes one expected response.
  always @(negedge clk_i) begin
    if (bus.valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer got transfer expected none at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("ready", 32'(bus.ready), 32'd1);
        chk("error", 32'(bus.error), 32'(mon_e.err));
        chk("interr_o", 32'(interr_o), 32'(mon_e.irq));
        if (mon_e.chk_rd) chk("rdata", bus.rdata, mon_e.rdata);
      end
    end
  end

  task automatic tick(input logic [99:0] s);
    scrub_i = s;
    @(posedge clk_i);
    #1;
  endtask

  task automatic xfer(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] exp_rd,
                      input logic exp_err, input logic exp_irq);
    exp_t e;
    e.rdata  = exp_rd;
    e.chk_rd = ~wr;
    e.err    = exp_err;
    e.irq    = exp_irq;
    sb_q.push_back(e);
    bus.valid = 1'b1;
    bus.write = wr;
    bus.addr  = a;
    bus.wdata = wd;
    bus.wstrb = ws;
    @(posedge clk_i);
    #1;
    bus.valid = 1'b0;
    bus.write = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = '0;
    bus.wstrb = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp_rd, input logic exp_irq);
    xfer(1'b0, a, 32'd0, 4'h0, exp_rd, 1'b0, exp_irq);
  endtask

  function automatic logic [99:0] onehot(input int i);
    logic [99:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    rst_i     = 1'b1;
    scrub_i   = '0;
    bus.valid = 1'b0;
    bus.write = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = '0;
    bus.wstrb = '0;
    tick('0);
    tick('1);
    rst_i = 1'b0;
    scrub_i = '0;

    // reset state
    rd(2'd0, 32'd0, 1'b0);
    rd(2'd1, 32'd0, 1'b0);
    rd(2'd2, 32'd0, 1'b0);
    rd(2'd3, 32'd0, 1'b0);

    // walking one: interrupt must not be set before the 100th edge
    for (int i = 0; i < 99; i++) tick(onehot(i));
    scrub_i = onehot(99);
    rd(2'd3, 32'd0, 1'b0);
    scrub_i = '0;
    rd(2'd1, 32'd1, 1'b1);
    rd(2'd0, 32'd100, 1'b1);
    rd(2'd2, 32'h0000_0064, 1'b1);
    rd(2'd3, 32'd1, 1'b1);

    // illegal and ineffective writes
    xfer(1'b1, 2'd0, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b1, 1'b1);
    xfer(1'b1, 2'd2, 32'h0000_0000, 4'hF, 32'd0, 1'b1, 1'b1);
    rd(2'd0, 32'd100, 1'b1);
    xfer(1'b1, 2'd3, 32'h0000_0000, 4'hF, 32'd0, 1'b0, 1'b1);
    xfer(1'b1, 2'd3, 32'h0000_0001, 4'hE, 32'd0, 1'b0, 1'b1);
    rd(2'd3, 32'd1, 1'b1);

    // clear wins over concurrent flips
    scrub_i = 100'h3;
    xfer(1'b1, 2'd3, 32'h0000_0001, 4'hF, 32'd0, 1'b0, 1'b1);
    scrub_i = '0;
    rd(2'd0, 32'd0, 1'b0);
    rd(2'd1, 32'd0, 1'b0);
    rd(2'd2, 32'd0, 1'b0);
    rd(2'd3, 32'd0, 1'b0);

    // all-ones in a single cycle
    tick('1);
    scrub_i = '0;
    rd(2'd1, 32'd100, 1'b1);
    rd(2'd0, 32'd100, 1'b1);
    rd(2'd2, 32'd1, 1'b1);
    rd(2'd3, 32'd1, 1'b1);

    // saturation of ERR_CNT
    xfer(1'b1, 2'd3, 32'h0000_0001, 4'h1, 32'd0, 1'b0, 1'b1);
    force dut.err_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.err_cnt;
    scrub_i = 100'h1F;
    rd(2'd0, 32'hFFFF_FFFD, 1'b0);
    scrub_i = '0;
    rd(2'd0, 32'hFFFF_FFFF, 1'b1);
    tick(100'h1F);
    scrub_i = '0;
    rd(2'd0, 32'hFFFF_FFFF, 1'b1);
    rd(2'd2, 32'd2, 1'b1);

    // reset in the middle of accumulation
    rst_i = 1'b1;
    tick('0);
    rst_i = 1'b0;
    for (int i = 0; i < 50; i++) tick(onehot(i));
    rst_i = 1'b1;
    tick('1);
    rst_i = 1'b0;
    scrub_i = '0;
    rd(2'd0, 32'd0, 1'b0);
    rd(2'd2, 32'd0, 1'b0);
    rd(2'd3, 32'd0, 1'b0);
    for (int i = 0; i < 99; i++) tick(onehot(i));
    scrub_i = '0;
    rd(2'd3, 32'd0, 1'b0);
    rd(2'd0, 32'd99, 1'b0);
    rd(2'd2, 32'd99, 1'b0);

    @(negedge clk_i);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
